cpu_pc_seq: RTL and testbench
=============================

Name: cpu_pc_seq

Overview:
- Parametrised program-counter sequencer; next generation of the single-cycle PC update unit.
- Adds stall hold, a one-entry pending-redirect buffer (a redirect arriving during a stall is not lost), latched interrupt entry with exception-PC capture, and kernel-bit protection.
- Sits at the head of the fetch stage: drives PC to instruction memory and takes redirects from decode/execute.

Parameters:
- ADDR_W, 32, PC width; must be >= 30.
- RESET_VEC, 32'h8000_0000, PC loaded on reset.
- ILLOP_VEC, 32'h8000_0004, illegal-op / interrupt entry vector.
- XADR_VEC, 32'h8000_0008, exception entry vector.
- JT_W, 26, jump-target field width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- PCSrc  in  3  redirect select: 000 seq, 001 branch, 010 jump, 011 jr, 100 ILLOP, 101 XADR; 110/111 treated as 000.
- ALUOut  in  1  branch condition; used only when PCSrc=001.
- JT  in  JT_W  jump target field.
- ConBA  in  ADDR_W  branch target.
- DatabusA  in  ADDR_W  register target for jr.
- stall  in  1  hold PC this cycle.
- irq  in  1  interrupt request, level-sensitive.
- PC  out  ADDR_W  current fetch address.
- EPC  out  ADDR_W  return address captured on interrupt/exception entry.
- redirect_pend  out  1  a redirect is buffered during a stall.

Behaviour:
- Reset (reset=0, async): PC=RESET_VEC, EPC=0, redirect_pend=0, irq latch cleared, state=RUN.
- PCp4 = PC+4, wraps modulo 2^ADDR_W.
- Target per PCSrc:
  - 000: PCp4.
  - 001: ConBA if ALUOut else PCp4.
  - 010: {PCp4[ADDR_W-1:28], JT, 2'b00}.
  - 011: DatabusA.
  - 100: ILLOP_VEC.
  - 101: XADR_VEC.
- Kernel protection: for 010/011, when PC[ADDR_W-1]=0, bit ADDR_W-1 of the target is forced to 0 (user code cannot enter kernel by jump). Branch targets are unaffected.
- irq is sampled every cycle into irq_lat. irq_lat is serviced only when PC[ADDR_W-1]=0 and stall=0: PC<=ILLOP_VEC, EPC<=PCp4 of the current cycle's sequential path, irq_lat cleared.
- irq has priority over any PCSrc redirect in the same cycle. A redirect that loses to irq is discarded.
- PCSrc 100/101 also load EPC<=PCp4.
- State machine:
  - RUN, stall=0: PC<=target, 1-cycle latency.
  - RUN, stall=1, PCSrc!=000: capture target in pend_reg, redirect_pend<=1, go to HOLD; PC holds.
  - RUN, stall=1, PCSrc=000: PC holds, stay in RUN.
  - HOLD, stall=1: PC holds. A new non-seq PCSrc overwrites pend_reg (youngest wins).
  - HOLD, stall=0: PC<=pend_reg (incoming PCSrc ignored that cycle), redirect_pend<=0, go to RUN.
  - irq is not serviced in HOLD; it is serviced in the first RUN cycle with stall=0.
- Async reset mid-HOLD drops the buffered redirect.

Optional Feature:
- Macro PC_MISALIGN_TRAP_EN.
- Defined: a jr target with DatabusA[1:0]!=0 redirects to XADR_VEC, loads EPC<=PCp4, and pulses output misalign (1 cycle, reset 0).
- Undefined: target low two bits are forced to 00 silently; the misalign port is absent.

Decomposition:
- Package cpu_pc_pkg holds:
  - PCSrc encodings PC_SEQ/PC_BR/PC_J/PC_JR/PC_ILLOP/PC_XADR.
  - State encoding RUN/HOLD.
  - Default vector constants.
- Sub-module cpu_pc_target: purely combinational target mux plus kernel protection, instantiated once.

Test Plan:
- Reset release, PCSrc=000, 4 cycles -> PC 8000_0000, 8000_0004, 8000_0008, 8000_000C.
- PC=0000_0100; PCSrc=001, ConBA=0000_0200: ALUOut=1 -> PC=0000_0200; ALUOut=0 -> PC=0000_0104.
- User PC=0000_0100, PCSrc=011, DatabusA=8000_0400 -> PC=0000_0400; same from kernel PC=8000_0100 -> 8000_0400. PCSrc=010, JT=26'h20, PC=0000_0100 -> PC=0000_0080.
- stall=1 with PCSrc=010 for 3 cycles -> PC frozen, redirect_pend=1; stall=0 -> next PC is jump target, redirect_pend=0.
- User PC=0000_0100, irq=1 together with PCSrc=001, ALUOut=1 -> PC=8000_0004, EPC=0000_0104. From kernel PC, irq is held latched and not taken.
- reset asserted in HOLD -> PC=8000_0000 immediately, redirect_pend=0. With PC_MISALIGN_TRAP_EN: jr to 0000_0102 -> PC=8000_0008, misalign pulse.

Source files
------------

// File: rtl/cpu_pc_pkg.sv
// Shared definitions for the program-counter sequencer: redirect-select
// encodings, sequencer state encoding and default vector constants.
package cpu_pc_pkg;

  // Redirect select encodings (110/111 behave as sequential)
  localparam logic [2:0] PC_SEQ   = 3'b000;
  localparam logic [2:0] PC_BR    = 3'b001;
  localparam logic [2:0] PC_J     = 3'b010;
  localparam logic [2:0] PC_JR    = 3'b011;
  localparam logic [2:0] PC_ILLOP = 3'b100;
  localparam logic [2:0] PC_XADR  = 3'b101;

  // Sequencer states
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  // Default geometry and vectors
  localparam int          DEF_ADDR_W    = 32;
  localparam int          DEF_JT_W      = 26;
  localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] DEF_XADR_VEC  = 32'h8000_0008;

  // True for selects that actually redirect the fetch stream
  function automatic logic is_redirect(input logic [2:0] sel);
    return (sel != PC_SEQ) && (sel <= PC_XADR);
  endfunction

endpackage

// File: rtl/cpu_pc_target.sv
// Combinational next-PC target mux with kernel-bit protection.
// Optional macro PC_MISALIGN_TRAP_EN: a misaligned jr traps to the
// exception vector instead of being silently aligned.
module cpu_pc_target
  import cpu_pc_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                JT_W      = DEF_JT_W,
  parameter logic [ADDR_W-1:0] ILLOP_VEC = ADDR_W'(DEF_ILLOP_VEC),
  parameter logic [ADDR_W-1:0] XADR_VEC  = ADDR_W'(DEF_XADR_VEC)
) (
  input  logic [2:0]        PCSrc,
  input  logic              ALUOut,
  input  logic [JT_W-1:0]   JT,
  input  logic [ADDR_W-1:0] ConBA,
  input  logic [ADDR_W-1:0] DatabusA,
  input  logic [ADDR_W-1:0] pcp4,
  input  logic              kernel,
  output logic [ADDR_W-1:0] target,
  output logic              load_epc
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  // Select the redirect target; jumps from user code may not set the kernel bit
  always_comb begin
    target   = pcp4;
    load_epc = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    misalign = 1'b0;
`endif
    case (PCSrc)
      PC_BR: begin
        if (ALUOut) target = ConBA;
      end
      PC_J: begin
        target = {pcp4[ADDR_W-1:28], 28'({JT, 2'b00})};
        if (!kernel) target[ADDR_W-1] = 1'b0;
      end
      PC_JR: begin
`ifdef PC_MISALIGN_TRAP_EN
        if (DatabusA[1:0] != 2'b00) begin
          // The trap is an exception entry, so it is exempt from protection
          target   = XADR_VEC;
          load_epc = 1'b1;
          misalign = 1'b1;
        end else begin
          target = DatabusA;
          if (!kernel) target[ADDR_W-1] = 1'b0;
        end
`else
        target = DatabusA & ~ADDR_W'(3);
        if (!kernel) target[ADDR_W-1] = 1'b0;
`endif
      end
      PC_ILLOP: begin
        target   = ILLOP_VEC;
        load_epc = 1'b1;
      end
      PC_XADR: begin
        target   = XADR_VEC;
        load_epc = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_pc_seq.sv
// Program-counter sequencer at the head of fetch: stall hold, one-entry
// pending-redirect buffer, latched interrupt entry with EPC capture and
// kernel-bit protection.
// Optional macro PC_MISALIGN_TRAP_EN adds the misaligned-jr trap and the
// one-cycle misalign output.
module cpu_pc_seq
  import cpu_pc_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] ILLOP_VEC = ADDR_W'(DEF_ILLOP_VEC),
  parameter logic [ADDR_W-1:0] XADR_VEC  = ADDR_W'(DEF_XADR_VEC),
  parameter int                JT_W      = DEF_JT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        PCSrc,
  input  logic              ALUOut,
  input  logic [JT_W-1:0]   JT,
  input  logic [ADDR_W-1:0] ConBA,
  input  logic [ADDR_W-1:0] DatabusA,
  input  logic              stall,
  input  logic              irq,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] EPC,
  output logic              redirect_pend
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  if (ADDR_W < 30) begin : g_width_check
    $error("cpu_pc_seq: ADDR_W must be at least 30");
  end

  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] epc_reg, epc_next;
  logic [ADDR_W-1:0] pend_reg, pend_next;
  logic              pend_epc_reg, pend_epc_next;
  logic [0:0]        state_reg, state_next;
  logic              irq_lat_reg, irq_lat_next;

  logic [ADDR_W-1:0] pcp4;
  logic              kernel;
  logic              irq_pend;
  logic [ADDR_W-1:0] tgt;
  logic              tgt_ld;
`ifdef PC_MISALIGN_TRAP_EN
  logic              tgt_mis;
  logic              pend_mis_reg, pend_mis_next;
  logic              mis_reg, mis_next;
`endif

  assign pcp4   = pc_reg + ADDR_W'(4);
  assign kernel = pc_reg[ADDR_W-1];
  // A request arriving this cycle counts as well as one latched earlier
  assign irq_pend = irq | irq_lat_reg;

  cpu_pc_target #(
    .ADDR_W    (ADDR_W),
    .JT_W      (JT_W),
    .ILLOP_VEC (ILLOP_VEC),
    .XADR_VEC  (XADR_VEC)
  ) u_target (
    .PCSrc    (PCSrc),
    .ALUOut   (ALUOut),
    .JT       (JT),
    .ConBA    (ConBA),
    .DatabusA (DatabusA),
    .pcp4     (pcp4),
    .kernel   (kernel),
    .target   (tgt),
    .load_epc (tgt_ld)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misalign (tgt_mis)
`endif
  );

  // Next-state: release buffered redirect, buffer under stall, take irq, or follow target
  always_comb begin
    pc_next       = pc_reg;
    epc_next      = epc_reg;
    pend_next     = pend_reg;
    pend_epc_next = pend_epc_reg;
    state_next    = state_reg;
    irq_lat_next  = irq_pend;
`ifdef PC_MISALIGN_TRAP_EN
    pend_mis_next = pend_mis_reg;
    mis_next      = 1'b0;
`endif
    if (state_reg == HOLD) begin
      if (!stall) begin
        // Buffered redirect wins; this cycle's PCSrc is ignored
        pc_next    = pend_reg;
        state_next = RUN;
        if (pend_epc_reg) epc_next = pcp4;
`ifdef PC_MISALIGN_TRAP_EN
        mis_next = pend_mis_reg;
`endif
      end else if (is_redirect(PCSrc)) begin
        // Youngest redirect replaces the buffered one
        pend_next     = tgt;
        pend_epc_next = tgt_ld;
`ifdef PC_MISALIGN_TRAP_EN
        pend_mis_next = tgt_mis;
`endif
      end
    end else if (stall) begin
      if (is_redirect(PCSrc)) begin
        pend_next     = tgt;
        pend_epc_next = tgt_ld;
        state_next    = HOLD;
`ifdef PC_MISALIGN_TRAP_EN
        pend_mis_next = tgt_mis;
`endif
      end
    end else if (irq_pend && !kernel) begin
      // Interrupt entry discards any redirect presented in the same cycle
      pc_next      = ILLOP_VEC;
      epc_next     = pcp4;
      irq_lat_next = 1'b0;
    end else begin
      pc_next = tgt;
      if (tgt_ld) epc_next = pcp4;
`ifdef PC_MISALIGN_TRAP_EN
      mis_next = tgt_mis;
`endif
    end
  end

  // State registers; reset drops any buffered redirect and latched irq
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg       <= RESET_VEC;
      epc_reg      <= '0;
      pend_reg     <= '0;
      pend_epc_reg <= 1'b0;
      state_reg    <= RUN;
      irq_lat_reg  <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      pend_mis_reg <= 1'b0;
      mis_reg      <= 1'b0;
`endif
    end else begin
      pc_reg       <= pc_next;
      epc_reg      <= epc_next;
      pend_reg     <= pend_next;
      pend_epc_reg <= pend_epc_next;
      state_reg    <= state_next;
      irq_lat_reg  <= irq_lat_next;
`ifdef PC_MISALIGN_TRAP_EN
      pend_mis_reg <= pend_mis_next;
      mis_reg      <= mis_next;
`endif
    end
  end

  assign PC            = pc_reg;
  assign EPC           = epc_reg;
  assign redirect_pend = (state_reg == HOLD);
`ifdef PC_MISALIGN_TRAP_EN
  assign misalign      = mis_reg;
`endif

endmodule

// File: tb/tb_cpu_pc_seq.sv
// Self-checking bench for cpu_pc_seq: directed scenarios followed by
// randomized traffic against a behavioural model of the sequencer.
module tb_cpu_pc_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  PCSrc = 3'd0;
  logic        ALUOut = 1'b0;
  logic [25:0] JT = 26'd0;
  logic [31:0] ConBA = 32'd0;
  logic [31:0] DatabusA = 32'd0;
  logic        stall = 1'b0;
  logic        irq = 1'b0;
  logic [31:0] PC, EPC;
  logic        redirect_pend;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_pass = 0;
  int n_total = 0;

  // Model state: PC, EPC, pending buffer (valid/target/epc/misalign), irq latch, misalign pulse
  logic [31:0] m_pc, m_epc, m_pt;
  logic        m_pv, m_pe, m_pm, m_il, m_mis;

  cpu_pc_seq dut (
    .clk           (clk),
    .reset         (reset),
    .PCSrc         (PCSrc),
    .ALUOut        (ALUOut),
    .JT            (JT),
    .ConBA         (ConBA),
    .DatabusA      (DatabusA),
    .stall         (stall),
    .irq           (irq),
    .PC            (PC),
    .EPC           (EPC),
    .redirect_pend (redirect_pend)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misalign      (misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h8000_0000; m_epc = 32'd0; m_pt = 32'd0;
    m_pv = 1'b0; m_pe = 1'b0; m_pm = 1'b0; m_il = 1'b0; m_mis = 1'b0;
  endtask

  // One clock of the sequencer described in terms of its rules
  task automatic model_step();
    logic [31:0] p4, tgt;
    logic        user, ld, mis, irq_now;
    int          sel;
    p4      = m_pc + 32'd4;
    user    = (m_pc < 32'h8000_0000);
    sel     = (PCSrc > 3'd5) ? 0 : int'(PCSrc);
    irq_now = irq | m_il;
    ld = 1'b0; mis = 1'b0;
    case (sel)
      0: tgt = p4;
      1: tgt = ALUOut ? ConBA : p4;
      2: begin
        tgt = (p4 & 32'hF000_0000) + ({6'd0, JT} * 32'd4);
        if (user) tgt = tgt % 32'h8000_0000;
      end
      3: begin
`ifdef PC_MISALIGN_TRAP_EN
        if (DatabusA % 4 != 0) begin
          tgt = 32'h8000_0008; ld = 1'b1; mis = 1'b1;
        end else begin
          tgt = DatabusA;
          if (user) tgt = tgt % 32'h8000_0000;
        end
`else
        tgt = DatabusA - (DatabusA % 4);
        if (user) tgt = tgt % 32'h8000_0000;
`endif
      end
      4: begin tgt = 32'h8000_0004; ld = 1'b1; end
      default: begin tgt = 32'h8000_0008; ld = 1'b1; end
    endcase
    m_mis = 1'b0;
    if (m_pv) begin
      if (!stall) begin
        m_pc = m_pt; if (m_pe) m_epc = p4; m_mis = m_pm; m_pv = 1'b0;
      end else if (sel != 0) begin
        m_pt = tgt; m_pe = ld; m_pm = mis;
      end
      m_il = irq_now;
    end else if (stall) begin
      if (sel != 0) begin m_pv = 1'b1; m_pt = tgt; m_pe = ld; m_pm = mis; end
      m_il = irq_now;
    end else if (irq_now && user) begin
      m_pc = 32'h8000_0004; m_epc = p4; m_il = 1'b0;
    end else begin
      m_pc = tgt; if (ld) m_epc = p4; m_mis = mis; m_il = irq_now;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    PCSrc = 3'd0; ALUOut = 1'b0; JT = 26'd0; ConBA = 32'd0;
    DatabusA = 32'd0; stall = 1'b0; irq = 1'b0;
  endtask

  // Reach an arbitrary PC: interrupt vector (kernel), then jr
  task automatic goto_pc(input logic [31:0] a);
    idle_inputs();
    PCSrc = 3'b100; step();
    PCSrc = 3'b011; DatabusA = a; step();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_total++; if (PC !== 32'h8000_0000) $display("FAIL reset_pc: got %h expected %h", PC, 32'h8000_0000); else n_pass++;
    n_total++; if (EPC !== 32'h0) $display("FAIL reset_epc: got %h expected %h", EPC, 32'h0); else n_pass++;
    n_total++; if (redirect_pend !== 1'b0) $display("FAIL reset_pend: got %b expected 0", redirect_pend); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_seq();
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) begin
      exp = 32'h8000_0000 + 32'(4 * i);
      n_total++; if (PC !== exp) $display("FAIL seq_pc[%0d]: got %h expected %h", i, PC, exp); else n_pass++;
      step();
    end
  endtask

  task automatic test_branch();
    goto_pc(32'h0000_0100);
    PCSrc = 3'b001; ConBA = 32'h0000_0200; ALUOut = 1'b1; step();
    n_total++; if (PC !== 32'h0000_0200) $display("FAIL branch_taken: got %h expected %h", PC, 32'h200); else n_pass++;
    goto_pc(32'h0000_0100);
    PCSrc = 3'b001; ConBA = 32'h0000_0200; ALUOut = 1'b0; step();
    n_total++; if (PC !== 32'h0000_0104) $display("FAIL branch_not_taken: got %h expected %h", PC, 32'h104); else n_pass++;
  endtask

  task automatic test_jr_jump();
    goto_pc(32'h0000_0100);
    PCSrc = 3'b011; DatabusA = 32'h8000_0400; step();
    n_total++; if (PC !== 32'h0000_0400) $display("FAIL jr_user_protect: got %h expected %h", PC, 32'h400); else n_pass++;
    goto_pc(32'h8000_0100);
    PCSrc = 3'b011; DatabusA = 32'h8000_0400; step();
    n_total++; if (PC !== 32'h8000_0400) $display("FAIL jr_kernel: got %h expected %h", PC, 32'h8000_0400); else n_pass++;
    goto_pc(32'h0000_0100);
    PCSrc = 3'b010; JT = 26'h20; step();
    n_total++; if (PC !== 32'h0000_0080) $display("FAIL jump_user: got %h expected %h", PC, 32'h80); else n_pass++;
  endtask

  task automatic test_stall();
    goto_pc(32'h0000_0100);
    stall = 1'b1; PCSrc = 3'b010; JT = 26'h20;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++; if (PC !== 32'h0000_0100) $display("FAIL stall_hold_pc[%0d]: got %h expected %h", i, PC, 32'h100); else n_pass++;
      n_total++; if (redirect_pend !== 1'b1) $display("FAIL stall_pend[%0d]: got %b expected 1", i, redirect_pend); else n_pass++;
    end
    // Incoming branch on the release cycle must be ignored
    stall = 1'b0; PCSrc = 3'b001; ConBA = 32'h0000_0900; ALUOut = 1'b1; step();
    n_total++; if (PC !== 32'h0000_0080) $display("FAIL stall_release_pc: got %h expected %h", PC, 32'h80); else n_pass++;
    n_total++; if (redirect_pend !== 1'b0) $display("FAIL stall_release_pend: got %b expected 0", redirect_pend); else n_pass++;
    idle_inputs(); step();
    n_total++; if (PC !== 32'h0000_0084) $display("FAIL stall_after_pc: got %h expected %h", PC, 32'h84); else n_pass++;
  endtask

  task automatic test_irq();
    goto_pc(32'h0000_0100);
    irq = 1'b1; PCSrc = 3'b001; ConBA = 32'h0000_0200; ALUOut = 1'b1; step();
    idle_inputs();
    n_total++; if (PC !== 32'h8000_0004) $display("FAIL irq_entry_pc: got %h expected %h", PC, 32'h8000_0004); else n_pass++;
    n_total++; if (EPC !== 32'h0000_0104) $display("FAIL irq_entry_epc: got %h expected %h", EPC, 32'h104); else n_pass++;
    goto_pc(32'h8000_0100);
    irq = 1'b1; step();
    irq = 1'b0; step();
    n_total++; if (PC !== 32'h8000_0108) $display("FAIL irq_kernel_masked: got %h expected %h", PC, 32'h8000_0108); else n_pass++;
    PCSrc = 3'b011; DatabusA = 32'h0000_0300; step();
    n_total++; if (PC !== 32'h0000_0300) $display("FAIL irq_kernel_return: got %h expected %h", PC, 32'h300); else n_pass++;
    idle_inputs(); step();
    n_total++; if (PC !== 32'h8000_0004) $display("FAIL irq_latched_pc: got %h expected %h", PC, 32'h8000_0004); else n_pass++;
    n_total++; if (EPC !== 32'h0000_0304) $display("FAIL irq_latched_epc: got %h expected %h", EPC, 32'h304); else n_pass++;
  endtask

  task automatic test_reset_in_hold();
    goto_pc(32'h0000_0100);
    stall = 1'b1; PCSrc = 3'b011; DatabusA = 32'h0000_0500; step();
    n_total++; if (redirect_pend !== 1'b1) $display("FAIL hold_entry_pend: got %b expected 1", redirect_pend); else n_pass++;
    #3 reset = 1'b0;
    #1;
    n_total++; if (PC !== 32'h8000_0000) $display("FAIL async_reset_pc: got %h expected %h", PC, 32'h8000_0000); else n_pass++;
    n_total++; if (redirect_pend !== 1'b0) $display("FAIL async_reset_pend: got %b expected 0", redirect_pend); else n_pass++;
    @(posedge clk); #1;
    idle_inputs(); model_reset(); reset = 1'b1;
    step();
    n_total++; if (PC !== 32'h8000_0004) $display("FAIL reset_drops_pend: got %h expected %h", PC, 32'h8000_0004); else n_pass++;
  endtask

  task automatic test_jr_align();
    goto_pc(32'h0000_0100);
    PCSrc = 3'b011; DatabusA = 32'h0000_0102; step();
`ifdef PC_MISALIGN_TRAP_EN
    n_total++; if (PC !== 32'h8000_0008) $display("FAIL misalign_pc: got %h expected %h", PC, 32'h8000_0008); else n_pass++;
    n_total++; if (EPC !== 32'h0000_0104) $display("FAIL misalign_epc: got %h expected %h", EPC, 32'h104); else n_pass++;
    n_total++; if (misalign !== 1'b1) $display("FAIL misalign_pulse: got %b expected 1", misalign); else n_pass++;
    idle_inputs(); step();
    n_total++; if (misalign !== 1'b0) $display("FAIL misalign_clear: got %b expected 0", misalign); else n_pass++;
`else
    n_total++; if (PC !== 32'h0000_0100) $display("FAIL jr_align_pc: got %h expected %h", PC, 32'h100); else n_pass++;
    idle_inputs();
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      PCSrc    = 3'($urandom_range(0, 7));
      ALUOut   = 1'($urandom);
      JT       = 26'($urandom);
      ConBA    = $urandom & 32'hFFFF_FFFC;
      DatabusA = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      stall    = ($urandom_range(0, 2) == 0);
      irq      = ($urandom_range(0, 9) == 0);
      step();
      n_total++; if (PC !== m_pc) $display("FAIL rand_pc[%0d]: got %h expected %h", i, PC, m_pc); else n_pass++;
      n_total++; if (EPC !== m_epc) $display("FAIL rand_epc[%0d]: got %h expected %h", i, EPC, m_epc); else n_pass++;
      n_total++; if (redirect_pend !== m_pv) $display("FAIL rand_pend[%0d]: got %b expected %b", i, redirect_pend, m_pv); else n_pass++;
`ifdef PC_MISALIGN_TRAP_EN
      n_total++; if (misalign !== m_mis) $display("FAIL rand_misalign[%0d]: got %b expected %b", i, misalign, m_mis); else n_pass++;
`endif
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_jr_jump();
    test_stall();
    test_irq();
    test_reset_in_hold();
    test_jr_align();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
